// File: rtl/mem_bus_loader_pkg.sv
// Shared constants for the byte-serial memory bus loader: command/response
// codes and the legacy-compatible FSM state encoding.
package mem_bus_loader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_BUS  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

endpackage

// File: rtl/mem_bus_loader_timeout.sv
// Bus wait watchdog for mem_bus_loader; only compiled when
// MEM_BUS_LOADER_TIMEOUT_EN is defined.
`ifdef MEM_BUS_LOADER_TIMEOUT_EN
module bus_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic mem_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    // Fires during the LIMIT-th enabled cycle so the owner can leave on that edge.
    assign expired = enable && (count == W'(LIMIT - 1));

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/mem_bus_loader.sv
// Byte-stream command loader: 'W' addr[4] data[4] / 'R' addr[4] drives one
// memory bus transfer and answers on tx. Optional bus watchdog: MEM_BUS_LOADER_TIMEOUT_EN.
module mem_bus_loader
    import mem_bus_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        mem_clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    logic [2:0]  state;
    logic [1:0]  byte_cnt;
    logic        is_write;
    logic [31:0] resp_sr;
    logic        rx_fire;
    logic        tx_fire;
    logic        bus_abort;

    // NOTE: handshake outputs decode the state register directly, so an async
    // reset drops mem_valid at once and mem_ready may depend on mem_valid combinationally.
    assign mem_valid = (state == ST_BUS);
    assign rx_ready  = (state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA);
    assign tx_valid  = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign mem_wstrb = (mem_valid && is_write) ? 4'hF : 4'h0;
    assign tx_data   = resp_sr[31:24];

    assign rx_fire = rx_valid && rx_ready;
    assign tx_fire = tx_valid && tx_ready;

`ifdef MEM_BUS_LOADER_TIMEOUT_EN
    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_bus_timeout_counter (
        .mem_clk (mem_clk),
        .rst_n   (rst_n),
        .clear   (!mem_valid),
        .enable  (mem_valid),
        .expired (bus_abort)
    );
`else
    assign bus_abort = 1'b0;
`endif

    // byte_cnt counts received bytes in ADDR/DATA and remaining bytes minus one in RESP.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            byte_cnt  <= 2'd0;
            is_write  <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            resp_sr   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        byte_cnt <= 2'd0;
                        if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                            is_write <= (rx_data == CMD_WRITE);
                            state    <= ST_ADDR;
                        end else begin
                            resp_sr <= {RSP_NAK, 24'h0};
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        mem_addr <= {mem_addr[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= is_write ? ST_DATA : ST_BUS;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        mem_wdata <= {mem_wdata[23:0], rx_data};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (mem_ready) begin
                        resp_sr  <= is_write ? {RSP_ACK, 24'h0} : mem_rdata;
                        byte_cnt <= is_write ? 2'd0 : 2'd3;
                        state    <= ST_RESP;
                    end else if (bus_abort) begin
                        resp_sr  <= {RSP_NAK, 24'h0};
                        byte_cnt <= 2'd0;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (tx_fire) begin
                        if (byte_cnt == 2'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            resp_sr  <= {resp_sr[23:0], 8'h00};
                            byte_cnt <= byte_cnt - 2'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_loader.sv
// Directed self-checking bench for mem_bus_loader; the timeout scenario runs
// only when MEM_BUS_LOADER_TIMEOUT_EN is defined.
module tb_mem_bus_loader;

    logic        mem_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_loader #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .mem_clk   (mem_clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 mem_clk = ~mem_clk;

    // Responder model: mem_ready rises after ready_delay waiting cycles (0 = combinational).
    int ready_delay = 0;
    int bus_cycles = 0;
    always @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n)          bus_cycles <= 0;
        else if (!mem_valid) bus_cycles <= 0;
        else                 bus_cycles <= bus_cycles + 1;
    end
    assign mem_ready = mem_valid && (bus_cycles >= ready_delay);

    // Bus monitor: counts mem_valid cycles and flags any request change while held.
    int          valid_cycles = 0;
    bit          unstable = 1'b0;
    logic [31:0] cap_addr = 32'h0;
    logic [31:0] cap_wdata = 32'h0;
    logic [3:0]  cap_wstrb = 4'h0;
    always @(negedge mem_clk) begin
        if (mem_valid) begin
            if (valid_cycles == 0) begin
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_wstrb = mem_wstrb;
            end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb) begin
                unstable = 1'b1;
            end
            valid_cycles++;
        end
    end

    task automatic clear_monitor();
        valid_cycles = 0;
        unstable = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        while (!rx_ready && guard < 50) begin
            @(negedge mem_clk);
            guard++;
        end
        if (!rx_ready) $display("FAIL rx_wait: rx_ready got %b, want 1", rx_ready);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge mem_clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    // Returns 8'hxx when tx_valid never rises so the caller's comparison fails.
    task automatic get_byte(output logic [7:0] b);
        int guard = 0;
        while (!tx_valid && guard < 50) begin
            @(negedge mem_clk);
            guard++;
        end
        if (!tx_valid) begin
            $display("FAIL tx_wait: tx_valid got %b, want 1", tx_valid);
            b = 8'hxx;
        end else begin
            b = tx_data;
            tx_ready = 1'b1;
            @(negedge mem_clk);
            tx_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== {1'b0, 32'h0, 32'h0, 4'h0}) begin
            n_err++;
            $display("FAIL reset_bus: got v=%b a=%h d=%h s=%h, want 0/0/0/0", mem_valid, mem_addr, mem_wdata, mem_wstrb);
        end
        n_cmp++;
        if ({tx_valid, tx_data, busy} !== {1'b0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL reset_tx: got tv=%b td=%h busy=%b, want 0/00/0", tx_valid, tx_data, busy);
        end
        @(negedge mem_clk);
        rst_n = 1'b1;
        @(negedge mem_clk);
        n_cmp++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rx_ready=%b busy=%b, want 1/0", rx_ready, busy);
        end
    endtask

    task automatic test_write();
        logic [7:0] b;
        clear_monitor();
        ready_delay = 0;
        send_byte(8'h57);
        send_word(32'h0000_0005);
        send_word(32'h0000_00A5);
        // One cycle after the 9th byte edge: in BUS, no response yet.
        n_cmp++;
        if (mem_valid !== 1'b1 || tx_valid !== 1'b0 || mem_wstrb !== 4'hF) begin
            n_err++;
            $display("FAIL wr_bus_cycle: got v=%b tv=%b s=%h, want 1/0/f", mem_valid, tx_valid, mem_wstrb);
        end
        @(negedge mem_clk);
        // Response visible now, so its first transfer edge is 2 cycles after the 9th byte edge.
        n_cmp++;
        if (tx_valid !== 1'b1 || mem_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wr_latency: got tv=%b v=%b, want 1/0", tx_valid, mem_valid);
        end
        get_byte(b);
        n_cmp++;
        if (b !== 8'h06) begin
            n_err++;
            $display("FAIL wr_ack: got %h, want 06", b);
        end
        n_cmp++;
        if (valid_cycles !== 1 || cap_addr !== 32'h5 || cap_wdata !== 32'hA5 || cap_wstrb !== 4'hF) begin
            n_err++;
            $display("FAIL wr_bus: got n=%0d a=%h d=%h s=%h, want 1/00000005/000000a5/f", valid_cycles, cap_addr, cap_wdata, cap_wstrb);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wr_idle: busy got %b, want 0", busy);
        end
    endtask

    task automatic test_read();
        logic [7:0] b;
        logic [7:0] exp_r [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        clear_monitor();
        ready_delay = 3;
        mem_rdata = 32'h1234_5678;
        send_byte(8'h52);
        send_word(32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            get_byte(b);
            n_cmp++;
            if (b !== exp_r[i]) begin
                n_err++;
                $display("FAIL rd_resp[%0d]: got %h, want %h", i, b, exp_r[i]);
            end
        end
        n_cmp++;
        if (valid_cycles !== 4 || unstable !== 1'b0 || cap_addr !== 32'h4 || cap_wstrb !== 4'h0) begin
            n_err++;
            $display("FAIL rd_bus: got n=%0d unstable=%b a=%h s=%h, want 4/0/00000004/0", valid_cycles, unstable, cap_addr, cap_wstrb);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rd_idle: busy got %b, want 0", busy);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] b;
        logic [7:0] exp_r [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        clear_monitor();
        ready_delay = 0;
        send_byte(8'h41);
        get_byte(b);
        n_cmp++;
        if (b !== 8'h15) begin
            n_err++;
            $display("FAIL bad_nak: got %h, want 15", b);
        end
        n_cmp++;
        if (valid_cycles !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bad_nobus: got n=%0d busy=%b, want 0/0", valid_cycles, busy);
        end
        mem_rdata = 32'hCAFE_F00D;
        send_byte(8'h52);
        send_word(32'h0000_0010);
        for (int i = 0; i < 4; i++) begin
            get_byte(b);
            n_cmp++;
            if (b !== exp_r[i]) begin
                n_err++;
                $display("FAIL bad_then_rd[%0d]: got %h, want %h", i, b, exp_r[i]);
            end
        end
        n_cmp++;
        if (valid_cycles !== 1 || cap_addr !== 32'h10) begin
            n_err++;
            $display("FAIL bad_then_rd_bus: got n=%0d a=%h, want 1/00000010", valid_cycles, cap_addr);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        logic [7:0] exp_r [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        int guard = 0;
        clear_monitor();
        ready_delay = 1;
        mem_rdata = 32'hA1B2_C3D4;
        send_byte(8'h52);
        send_word(32'h0000_0100);
        while (!tx_valid && guard < 50) begin
            @(negedge mem_clk);
            guard++;
        end
        // A command byte offered during the stall must not be taken.
        rx_valid = 1'b1;
        rx_data  = 8'h57;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hA1 || rx_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_stall[%0d]: got tv=%b td=%h rr=%b, want 1/a1/0", i, tx_valid, tx_data, rx_ready);
            end
            @(negedge mem_clk);
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            get_byte(b);
            n_cmp++;
            if (b !== exp_r[i]) begin
                n_err++;
                $display("FAIL bp_resp[%0d]: got %h, want %h", i, b, exp_r[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: got busy=%b tv=%b, want 0/0", busy, tx_valid);
        end
    endtask

    task automatic test_reset_in_bus();
        logic [7:0] b;
        clear_monitor();
        ready_delay = 1000;
        send_byte(8'h57);
        send_word(32'h0000_0040);
        send_word(32'hDEAD_BEEF);
        @(negedge mem_clk);
        @(negedge mem_clk);
        n_cmp++;
        if (mem_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rib_waiting: mem_valid got %b, want 1", mem_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_valid !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rib_async: got v=%b busy=%b tv=%b, want 0/0/0", mem_valid, busy, tx_valid);
        end
        @(negedge mem_clk);
        rst_n = 1'b1;
        @(negedge mem_clk);
        clear_monitor();
        ready_delay = 0;
        send_byte(8'h57);
        send_word(32'h0000_0008);
        send_word(32'h1122_3344);
        get_byte(b);
        n_cmp++;
        if (b !== 8'h06) begin
            n_err++;
            $display("FAIL rib_ack: got %h, want 06", b);
        end
        n_cmp++;
        if (valid_cycles !== 1 || cap_addr !== 32'h8 || cap_wdata !== 32'h1122_3344) begin
            n_err++;
            $display("FAIL rib_bus: got n=%0d a=%h d=%h, want 1/00000008/11223344", valid_cycles, cap_addr, cap_wdata);
        end
    endtask

`ifdef MEM_BUS_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] b;
        int guard = 0;
        clear_monitor();
        ready_delay = 1000;
        send_byte(8'h52);
        send_word(32'h0000_0020);
        while (mem_valid && guard < 50) begin
            @(negedge mem_clk);
            guard++;
        end
        n_cmp++;
        if (valid_cycles !== 8) begin
            n_err++;
            $display("FAIL to_cycles: mem_valid cycles got %0d, want 8", valid_cycles);
        end
        get_byte(b);
        n_cmp++;
        if (b !== 8'h15) begin
            n_err++;
            $display("FAIL to_nak: got %h, want 15", b);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL to_idle: busy got %b, want 0", busy);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_backpressure();
        test_reset_in_bus();
`ifdef MEM_BUS_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
